// File: rtl/seq_adder_pkg.sv
// Shared types and helpers for the sequential chunked adder/subtractor.
package seq_adder_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // Bits needed to count NCHUNK chunks; never less than one bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 1;
    while ((32'd1 << r) < n) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_chunk_adder_if.sv
// Operand/result handshake bundle for seq_chunk_adder.
interface seq_chunk_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  // Producer/consumer side driving operands and accepting results.
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );

  // Adder side.
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );
endinterface

// File: rtl/chunk_add.sv
// Combinational CHUNK-bit ripple-carry slice.
module chunk_add #(
  parameter int unsigned CHUNK = 1
) (
  input  logic [CHUNK-1:0] i_x,
  input  logic [CHUNK-1:0] i_y,
  input  logic             i_ci,
  output logic [CHUNK-1:0] o_s,
  output logic             o_co,
  output logic             o_c_msb
);

  logic [CHUNK:0] w_c;

  // Ripple through the slice one full adder per bit.
  always_comb begin
    w_c    = '0;
    o_s    = '0;
    w_c[0] = i_ci;
    for (int i = 0; i < int'(CHUNK); i++) begin
      o_s[i]   = i_x[i] ^ i_y[i] ^ w_c[i];
      w_c[i+1] = (i_x[i] & i_y[i]) | (i_x[i] & w_c[i]) | (i_y[i] & w_c[i]);
    end
  end

  assign o_co    = w_c[CHUNK];
  assign o_c_msb = w_c[CHUNK-1];

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands processed CHUNK bits per clock, LSB first.
module seq_chunk_adder
  import seq_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 1
) (
  input logic           clk,
  input logic           rst_n,
  seq_chunk_adder_if.slave bus
);

  localparam int unsigned NCHUNK = (CHUNK == 0) ? 1 : WIDTH / CHUNK;
  localparam int unsigned CW     = clog2(NCHUNK);

  if (CHUNK == 0 || WIDTH < 2 || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("seq_chunk_adder: WIDTH must be >= 2 and a multiple of CHUNK");
  end

  state_e           r_state;
  state_e           w_state_d;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic [CW-1:0]    r_k;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic [CHUNK-1:0] w_s;
  logic             w_co;
  logic             w_c_msb;
  logic [WIDTH-1:0] w_acc_d;
  logic             w_last;
  logic             w_accept;

  assign w_last   = (r_k == CW'(NCHUNK - 1));
  assign w_accept = bus.in_valid && (r_state == StIdle);

  chunk_add #(
    .CHUNK (CHUNK)
  ) u_chunk_add (
    .i_x     (r_opa[CHUNK-1:0]),
    .i_y     (r_opb[CHUNK-1:0]),
    .i_ci    (r_carry),
    .o_s     (w_s),
    .o_co    (w_co),
    .o_c_msb (w_c_msb)
  );

  // New sum bits enter at the top so the first (LSB) chunk ends up at bit 0.
  if (CHUNK == WIDTH) begin : g_acc_full
    assign w_acc_d = w_s;
  end else begin : g_acc_part
    assign w_acc_d = {w_s, r_acc[WIDTH-1:CHUNK]};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (bus.in_valid)  w_state_d = StRun;
      StRun:   if (w_last)        w_state_d = StDone;
      StDone:  if (bus.out_ready) w_state_d = StIdle;
      default:                    w_state_d = StIdle;
    endcase
  end

  // Operand shifting, carry chain and result capture; outputs only move on the final chunk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opa   <= '0;
      r_opb   <= '0;
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_k     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_opa   <= bus.a;
      r_opb   <= bus.sub ? ~bus.b : bus.b;
      r_carry <= bus.cin ^ bus.sub;
      r_k     <= '0;
      r_acc   <= '0;
    end else if (r_state == StRun) begin
      r_opa   <= r_opa >> CHUNK;
      r_opb   <= r_opb >> CHUNK;
      r_acc   <= w_acc_d;
      r_carry <= w_co;
      r_k     <= r_k + CW'(1);
      if (w_last) begin
        r_sum  <= w_acc_d;
        r_cout <= w_co;
        r_ovf  <= w_c_msb ^ w_co;
      end
    end
  end

  assign bus.in_ready  = (r_state == StIdle);
  assign bus.out_valid = (r_state == StDone);
  assign bus.busy      = (r_state != StIdle);
  assign bus.sum       = r_sum;
  assign bus.cout      = r_cout;
  assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Self-checking bench: four adder instances (8/1, 16/2, 16/4, 16/8) against an arithmetic model.
module tb_seq_chunk_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  iv  = '0;
  logic [3:0]  orr = '0;
  logic [15:0] d_a = '0;
  logic [15:0] d_b = '0;
  logic        d_cin = 1'b0;
  logic        d_sub = 1'b0;

  logic [3:0]  ir, ov, bz, co, of;
  logic [15:0] sm [4];

  int total = 0;
  int bad   = 0;

  seq_chunk_adder_if #(.WIDTH(8))  if0 ();
  seq_chunk_adder_if #(.WIDTH(16)) if1 ();
  seq_chunk_adder_if #(.WIDTH(16)) if2 ();
  seq_chunk_adder_if #(.WIDTH(16)) if3 ();

  assign if0.in_valid = iv[0];
  assign if1.in_valid = iv[1];
  assign if2.in_valid = iv[2];
  assign if3.in_valid = iv[3];
  assign if0.out_ready = orr[0];
  assign if1.out_ready = orr[1];
  assign if2.out_ready = orr[2];
  assign if3.out_ready = orr[3];
  assign if0.a = d_a[7:0];
  assign if0.b = d_b[7:0];
  assign if1.a = d_a;
  assign if1.b = d_b;
  assign if2.a = d_a;
  assign if2.b = d_b;
  assign if3.a = d_a;
  assign if3.b = d_b;
  assign if0.cin = d_cin;
  assign if1.cin = d_cin;
  assign if2.cin = d_cin;
  assign if3.cin = d_cin;
  assign if0.sub = d_sub;
  assign if1.sub = d_sub;
  assign if2.sub = d_sub;
  assign if3.sub = d_sub;

  assign ir = {if3.in_ready, if2.in_ready, if1.in_ready, if0.in_ready};
  assign ov = {if3.out_valid, if2.out_valid, if1.out_valid, if0.out_valid};
  assign bz = {if3.busy, if2.busy, if1.busy, if0.busy};
  assign co = {if3.cout, if2.cout, if1.cout, if0.cout};
  assign of = {if3.ovf, if2.ovf, if1.ovf, if0.ovf};
  assign sm[0] = {8'h00, if0.sum};
  assign sm[1] = if1.sum;
  assign sm[2] = if2.sum;
  assign sm[3] = if3.sum;

  seq_chunk_adder #(.WIDTH(8),  .CHUNK(1)) u_d0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  seq_chunk_adder #(.WIDTH(16), .CHUNK(2)) u_d1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) u_d2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
  seq_chunk_adder #(.WIDTH(16), .CHUNK(8)) u_d3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));

  function automatic int wd(input int sel);
    return (sel == 0) ? 8 : 16;
  endfunction

  function automatic int nch(input int sel);
    case (sel)
      0: return 8;
      1: return 8;
      2: return 4;
      default: return 2;
    endcase
  endfunction

  // Reference: exact integer arithmetic, then read off modulo sum, carry/no-borrow and
  // whether the signed result leaves the two's-complement range. Returns {ovf, cout, sum}.
  function automatic logic [17:0] ref_op(input int w, input logic [15:0] a, input logic [15:0] b,
                                         input logic ci, input logic sb);
    longint m, ua, ub, sa, sbv, r, sr;
    logic [17:0] res;
    m   = longint'(1) << w;
    ua  = longint'(a) & (m - 1);
    ub  = longint'(b) & (m - 1);
    sa  = (ua >= m / 2) ? ua - m : ua;
    sbv = (ub >= m / 2) ? ub - m : ub;
    if (sb) begin
      r  = ua - ub - longint'(ci);
      sr = sa - sbv - longint'(ci);
    end else begin
      r  = ua + ub + longint'(ci);
      sr = sa + sbv + longint'(ci);
    end
    res[15:0] = 16'(r & (m - 1));
    res[16]   = sb ? (r >= 0) : (r >= m);
    res[17]   = (sr < -(m / 2)) || (sr >= m / 2);
    return res;
  endfunction

  // Present one operation and return #1 after the accepting edge.
  task automatic start_op(input int sel, input logic [15:0] a, input logic [15:0] b,
                          input logic ci, input logic sb);
    @(negedge clk);
    d_a = a;
    d_b = b;
    d_cin = ci;
    d_sub = sb;
    iv[sel] = 1'b1;
    @(posedge clk);
    #1;
    iv[sel] = 1'b0;
  endtask

  // Count edges until out_valid; a count of 40 means the bound expired.
  task automatic wait_done(input int sel, output int lat);
    lat = 0;
    while (!ov[sel] && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    #3;
    total++;
    if (ir !== 4'hF || ov !== 4'h0 || bz !== 4'h0 || co !== 4'h0 || of !== 4'h0) begin
      bad++;
      $display("FAIL reset_flags: ir=%b ov=%b busy=%b cout=%b ovf=%b want 1111/0000/0000/0000/0000",
               ir, ov, bz, co, of);
    end
    total++;
    if (sm[0] !== 16'h0 || sm[2] !== 16'h0) begin
      bad++;
      $display("FAIL reset_sum: got %h/%h want 0000/0000", sm[0], sm[2]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    total++;
    if (ir !== 4'hF || bz !== 4'h0) begin
      bad++;
      $display("FAIL reset_release_idle: ir=%b busy=%b want 1111/0000", ir, bz);
    end
  endtask

  task automatic test_add_sub();
    logic [7:0] ta [6] = '{8'h35, 8'h7F, 8'hFF, 8'h10, 8'h80, 8'h05};
    logic [7:0] tb [6] = '{8'h4A, 8'h01, 8'h01, 8'h20, 8'h01, 8'h05};
    logic       tc [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic       ts [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [7:0] es [6] = '{8'h7F, 8'h80, 8'h01, 8'hF0, 8'h7F, 8'hFF};
    logic       ec [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic       eo [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    int lat;
    orr[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      start_op(0, {8'h00, ta[i]}, {8'h00, tb[i]}, tc[i], ts[i]);
      wait_done(0, lat);
      total++;
      if (lat !== 8) begin
        bad++;
        $display("FAIL dir%0d_latency: got %0d want 8", i, lat);
      end
      total++;
      if (sm[0][7:0] !== es[i] || co[0] !== ec[i] || of[0] !== eo[i]) begin
        bad++;
        $display("FAIL dir%0d_result: sum=%h cout=%b ovf=%b want %h/%b/%b",
                 i, sm[0][7:0], co[0], of[0], es[i], ec[i], eo[i]);
      end
      total++;
      if (ir[0] !== 1'b0) begin
        bad++;
        $display("FAIL dir%0d_ready_in_done: got %b want 0", i, ir[0]);
      end
      @(posedge clk);
      #1;
      total++;
      if (ir[0] !== 1'b1 || ov[0] !== 1'b0 || sm[0][7:0] !== es[i]) begin
        bad++;
        $display("FAIL dir%0d_after_handshake: ir=%b ov=%b sum=%h want 1/0/%h",
                 i, ir[0], ov[0], sm[0][7:0], es[i]);
      end
    end
    orr[0] = 1'b0;
  endtask

  task automatic test_backpressure();
    int lat;
    orr[0] = 1'b0;
    start_op(0, 16'h0012, 16'h0034, 1'b0, 1'b0);
    lat = 0;
    while (!ov[0] && lat < 40) begin
      @(negedge clk);
      iv[0] = 1'($urandom_range(0, 1));
      d_a = 16'($urandom);
      d_b = 16'($urandom);
      d_sub = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      lat++;
    end
    total++;
    if (lat !== 8) begin
      bad++;
      $display("FAIL bp_latency: got %0d want 8", lat);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      iv[0] = 1'($urandom_range(0, 1));
      d_a = 16'($urandom);
      @(posedge clk);
      #1;
      total++;
      if (sm[0][7:0] !== 8'h46 || co[0] !== 1'b0 || of[0] !== 1'b0 || ov[0] !== 1'b1 ||
          ir[0] !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold%0d: sum=%h cout=%b ovf=%b ov=%b ir=%b want 46/0/0/1/0",
                 c, sm[0][7:0], co[0], of[0], ov[0], ir[0]);
      end
    end
    @(negedge clk);
    iv[0] = 1'b0;
    orr[0] = 1'b1;
    @(posedge clk);
    #1;
    orr[0] = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (ir[0] !== 1'b1 || bz[0] !== 1'b0 || sm[0][7:0] !== 8'h46) begin
      bad++;
      $display("FAIL bp_release: ir=%b busy=%b sum=%h want 1/0/46", ir[0], bz[0], sm[0][7:0]);
    end
  endtask

  task automatic test_async_reset();
    int lat;
    start_op(0, 16'h0011, 16'h0022, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (ir[0] !== 1'b1 || ov[0] !== 1'b0 || bz[0] !== 1'b0 || sm[0] !== 16'h0 ||
        co[0] !== 1'b0 || of[0] !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: ir=%b ov=%b busy=%b sum=%h cout=%b ovf=%b want 1/0/0/00/0/0",
               ir[0], ov[0], bz[0], sm[0][7:0], co[0], of[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    orr[0] = 1'b1;
    start_op(0, 16'h0035, 16'h004A, 1'b0, 1'b0);
    wait_done(0, lat);
    total++;
    if (lat !== 8 || sm[0][7:0] !== 8'h7F || co[0] !== 1'b0 || of[0] !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_op: lat=%0d sum=%h cout=%b ovf=%b want 8/7f/0/0",
               lat, sm[0][7:0], co[0], of[0]);
    end
    @(posedge clk);
    #1;
    orr[0] = 1'b0;
  endtask

  task automatic test_wide();
    int lat;
    orr[2] = 1'b1;
    start_op(2, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    wait_done(2, lat);
    total++;
    if (lat !== 4) begin
      bad++;
      $display("FAIL wide_latency: got %0d want 4", lat);
    end
    total++;
    if (sm[2] !== 16'h8000 || co[2] !== 1'b0 || of[2] !== 1'b1) begin
      bad++;
      $display("FAIL wide_result: sum=%h cout=%b ovf=%b want 8000/0/1", sm[2], co[2], of[2]);
    end
    @(posedge clk);
    #1;
    orr[2] = 1'b0;
  endtask

  task automatic test_random();
    int lat;
    int sel;
    int dly;
    logic [15:0] ra, rb;
    logic rc, rs;
    logic [17:0] exp;
    logic [15:0] msk;
    for (int i = 0; i < 500; i++) begin
      sel = i % 4;
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      dly = $urandom_range(0, 2);
      msk = (sel == 0) ? 16'h00FF : 16'hFFFF;
      exp = ref_op(wd(sel), ra, rb, rc, rs);
      start_op(sel, ra, rb, rc, rs);
      wait_done(sel, lat);
      total++;
      if (lat !== nch(sel)) begin
        bad++;
        $display("FAIL rnd%0d_latency: dut%0d got %0d want %0d", i, sel, lat, nch(sel));
      end
      total++;
      if ((sm[sel] & msk) !== exp[15:0] || co[sel] !== exp[16] || of[sel] !== exp[17]) begin
        bad++;
        $display("FAIL rnd%0d_result: dut%0d a=%h b=%h cin=%b sub=%b sum=%h cout=%b ovf=%b want %h/%b/%b",
                 i, sel, ra & msk, rb & msk, rc, rs, sm[sel], co[sel], of[sel],
                 exp[15:0], exp[16], exp[17]);
      end
      repeat (dly) begin
        @(posedge clk);
        #1;
      end
      @(negedge clk);
      orr[sel] = 1'b1;
      @(posedge clk);
      #1;
      orr[sel] = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_add_sub();
    test_backpressure();
    test_async_reset();
    test_wide();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
